// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential divider.
// Provides the default operand width and the divider control state type.
package arith_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider16_if.sv
// Start/done handshake bundle for the sequential divider.
//   start, dividend, divisor : request and operands (master -> slave)
//   busy, done               : status (slave -> master)
//   quotient, remainder      : held result registers (slave -> master)
//   div_by_zero              : set with done when the divisor was 0
interface seq_divider16_if #(
  parameter int WIDTH = arith_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider16_div_step.sv
// One combinational restoring-division step.
//   pr      : partial remainder entering the step
//   bit_in  : next dividend bit shifted into the remainder
//   dvs     : divisor
//   pr_next : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] pr,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] pr_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;

  assign t     = {pr, bit_in};
  assign q_bit = (t >= {1'b0, dvs});

  // When the subtract happens t < 2*dvs, so the true difference is below
  // dvs and fits in WIDTH bits; modulo-2^WIDTH subtraction is exact here.
  assign pr_next = q_bit ? (t[WIDTH-1:0] - dvs) : t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of the start/done handshake (operands in,
//            busy/done/quotient/remainder/div_by_zero out)
// A zero divisor skips RUN and completes on the accepting edge with
// quotient all ones, remainder = dividend and div_by_zero set.
module seq_divider16
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider16_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  // The restoring step always leaves pr below dvs, so the top bit of the
  // WIDTH+1-bit remainder is always zero and is not stored.
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] pr_step;
  logic             q_bit;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             zero_div;
  logic             last_step;

  assign zero_div  = (bus.divisor == '0);
  assign last_step = (cnt == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr),
    .bit_in  (dq[WIDTH-1]),
    .dvs     (dvs),
    .pr_next (pr_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = zero_div ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq        <= '0;
      dvs       <= '0;
      pr        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        if (zero_div) begin
          quotient  <= '1;
          remainder <= bus.dividend;
          dbz       <= 1'b1;
        end else begin
          dq  <= bus.dividend;
          dvs <= bus.divisor;
          pr  <= '0;
          cnt <= CNT_W'(WIDTH - 1);
        end
      end
    end else if (state == RUN) begin
      pr <= pr_step;
      dq <= {dq[WIDTH-2:0], q_bit};
      if (last_step) begin
        quotient  <= {dq[WIDTH-2:0], q_bit};
        remainder <= pr_step;
        dbz       <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Status decodes straight from the state register; no start-to-output path.
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: a cycle-level behavioural model
// (plain / and % plus a completion countdown) compared every cycle, and
// directed operations with hand-computed literal results.
module tb_seq_divider16;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  seq_divider16_if #(.WIDTH(W)) bus ();

  seq_divider16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Behavioural model: results from / and %, done WIDTH edges after accept
  // (same edge for a zero divisor), one-cycle done, then idle again.
  logic         m_busy, m_done, m_dbz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
        m_dbz  <= 1'b0;
      end
      m_left <= m_left - 1;
    end else if (bus.start) begin
      m_busy <= 1'b1;
      if (bus.divisor == 0) begin
        m_done <= 1'b1;
        m_q    <= '1;
        m_r    <= bus.dividend;
        m_dbz  <= 1'b1;
      end else begin
        p_q    <= bus.dividend / bus.divisor;
        p_r    <= bus.dividend % bus.divisor;
        m_left <= W;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done);
    check("quotient", bus.quotient, m_q);
    check("remainder", bus.remainder, m_r);
    check("div_by_zero", bus.div_by_zero, m_dbz);
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input string tag);
    int lat = 0;
    wait_idle();
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = ~a;      // later operand changes must not matter
    bus.divisor  = b + 16'd5;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, edbz ? 0 : W);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, bus.div_by_zero, edbz);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, bus.done, 0);
    check({tag, "_busy_fall"}, bus.busy, 0);
    check({tag, "_q_hold"}, bus.quotient, eq);
  endtask

  int hs_q[3] = '{333, 277, 583};
  int hs_r[3] = '{1, 4, 0};

  initial begin
    int ndone;
    int last_k;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "basic");
    run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, "max_by_1");
    run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, "max_by_max");
    run_op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, "small");
    run_op(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, "zero_dividend");
    run_op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, "div0");
    run_op(16'd10, 16'd3, 16'd3, 16'd1, 1'b0, "after_div0");

    // start held high with operands changing every cycle
    wait_idle();
    bus.start = 1'b1;
    ndone = 0;
    last_k = 0;
    for (int k = 0; k < 54; k++) begin
      bus.dividend = 16'(1000 + 37 * k);
      bus.divisor  = 16'(3 + (k % 5));
      @(posedge clk); #1;
      if (bus.done) begin
        if (ndone < 3) begin
          check("hs_q", bus.quotient, hs_q[ndone]);
          check("hs_r", bus.remainder, hs_r[ndone]);
        end
        if (ndone == 0) check("hs_first_done_edge", k, W);
        else check("hs_gap", k - last_k, W + 2);
        last_k = k;
        ndone++;
      end
    end
    bus.start = 1'b0;
    check("hs_count", ndone, 3);

    // reset in the middle of an operation
    wait_idle();
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_q", bus.quotient, 0);
    check("midrst_r", bus.remainder, 0);
    check("midrst_dbz", bus.div_by_zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, "after_rst");

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider16.md
# seq_divider16

Sequential unsigned restoring divider, one quotient bit per clock. It sits beside the shift-and-add multiplier datapath as the inverse arithmetic unit, and it consumes operands through a start/done handshake. For a 16-bit dividend and divisor it produces quotient, remainder and a divide-by-zero flag.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width in bits; legal range 2..32.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous assert, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `dividend`  in  WIDTH: unsigned dividend; latched on the accepting edge.
- `divisor`  in  WIDTH: unsigned divisor; latched on the accepting edge.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; results are valid from this cycle onward.
- `quotient`  out  WIDTH: result register.
- `remainder`  out  WIDTH: result register.
- `div_by_zero`  out  1: set with `done` when the divisor was 0; held with the results.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN: on `start=1` with a nonzero divisor. On that edge:
  - latch `dividend` into shift register `dq`;
  - latch `divisor` into `dvs`;
  - clear the partial remainder `pr` (WIDTH+1 bits);
  - set the bit counter to WIDTH-1.
- IDLE → DONE: on `start=1` with `divisor==0`. This path skips RUN and writes:
  - `quotient` = all ones;
  - `remainder` = `dividend`;
  - `div_by_zero` = 1.
- RUN performs one step per edge:
  - form `t = {pr[WIDTH-1:0], dq[WIDTH-1]}`;
  - if `t >= {1'b0,dvs}`, set `pr = t - dvs` and shift 1 into `dq[0]`;
  - otherwise set `pr = t` and shift 0 into `dq[0]`;
  - shift `dq` left by one.
  - When the counter is 0, the step's results load `quotient` and `remainder` (`pr[WIDTH-1:0]`), clear `div_by_zero`, and the state goes to DONE. Otherwise the counter decrements.
- DONE: `done=1` for this single cycle. Unconditional → IDLE on the next edge.
- `start` is ignored in RUN and DONE; no queuing. Operand changes after the accepting edge have no effect.
- Result registers and `div_by_zero` hold their values until the next completion, including through IDLE.
- Arithmetic is unsigned only. The compare/subtract uses WIDTH+1 bits, so no overflow is possible.

## Timing
- Reset (async, `rst_n=0`) sets:
  - state to IDLE;
  - `busy=0`, `done=0`;
  - `quotient=0`, `remainder=0`, `div_by_zero=0`;
  - internal registers to 0.
- Reset mid-RUN aborts the operation immediately. No `done` is produced, and prior results are lost (zeroed).
- Normal latency, with edge 0 as the accepting edge:
  - RUN occupies edges 1..WIDTH;
  - `done` and the results are visible after edge WIDTH (16 for the default) and stay high until edge WIDTH+1;
  - the next `start` can be accepted at edge WIDTH+2.
- Divide-by-zero latency: `done` is visible after edge 0 and drops at edge 1. The next accept can occur at edge 2.
- `busy` rises after the accepting edge and falls together with `done`.
- Back-to-back throughput is one result per WIDTH+2 cycles.
- Combinational `start` → outputs paths are not allowed; all outputs are registered.

## Structure
- Shared package `arith_pkg`:
  - `DIV_WIDTH` default constant (16);
  - state typedef `div_state_t` {IDLE, RUN, DONE}, 2-bit encoding.
- Sub-module `div_step`: purely combinational single restoring step.
  - Inputs: `pr`, next dividend bit, `dvs`.
  - Outputs: new `pr`, quotient bit.
  - It is instantiated once; the FSM, counter and registers live in `seq_divider16`.

## Test plan
- Basic: 100 / 7 → after 16 cycles, `done` pulses; `quotient=14`, `remainder=2`, `div_by_zero=0`.
- Extremes: 0xFFFF / 1 → `quotient=0xFFFF`, `remainder=0`. Then 0xFFFF / 0xFFFF → `quotient=1`, `remainder=0`.
- Small dividend: 5 / 9 → `quotient=0`, `remainder=5`. Then 0 / 3 → `quotient=0`, `remainder=0`.
- Divide by zero: 1234 / 0 → `done` one cycle after accept; `quotient=0xFFFF`, `remainder=1234`, `div_by_zero=1`. A following 10 / 3 clears the flag (`quotient=3`, `remainder=1`).
- Handshake: hold `start=1` continuously with changing operands. Operations must be accepted only at IDLE, every 18 cycles, and each result must match the operands present at its accepting edge.
- Reset mid-op: assert `rst_n=0` 8 cycles into 1000 / 3. All outputs go to 0 asynchronously, with no `done`. After release, 1000 / 3 → `quotient=333`, `remainder=1` at normal latency.
